// File: rtl/sram_stage_sequencer.sv
// Top-level sequencer: loads an image over UART, runs the masked processing stages in
// index order, then hands the SRAM back to VGA. Owns the SRAM port multiplexer.
module sram_stage_sequencer #(
    parameter int unsigned NUM_STAGES = 3,
    parameter logic [25:0] RX_TIMEOUT = 26'd49999999,
    parameter bit          SKIP_UART  = 1'b0,
    localparam int unsigned AW  = 18,
    localparam int unsigned DW  = 16,
    localparam int unsigned TW  = 26,
    localparam int unsigned IW  = 3,
    localparam int unsigned IXW = IW + 1
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     Start_I,
    input  logic [NUM_STAGES-1:0]    Stage_mask_I,
    input  logic [AW-1:0]            UART_addr_I,
    input  logic [DW-1:0]            UART_wdata_I,
    input  logic                     UART_we_n_I,
    output logic                     UART_init_O,
    output logic                     UART_enable_O,
    output logic [NUM_STAGES-1:0]    Stage_enable_O,
    input  logic [NUM_STAGES-1:0]    Stage_done_I,
    input  logic [AW*NUM_STAGES-1:0] Stage_addr_I,
    input  logic [DW*NUM_STAGES-1:0] Stage_wdata_I,
    input  logic [NUM_STAGES-1:0]    Stage_we_n_I,
    input  logic [AW-1:0]            VGA_addr_I,
    output logic                     VGA_enable_O,
    output logic [AW-1:0]            SRAM_address_O,
    output logic [DW-1:0]            SRAM_write_data_O,
    output logic                     SRAM_we_n_O,
    output logic [2:0]               State_O,
    output logic [IW-1:0]            Stage_idx_O,
    output logic                     Busy_O
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UART_INIT = 3'd1,
        S_UART_WAIT = 3'd2,
        S_STAGE_RUN = 3'd3,
        S_STAGE_GAP = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IW-1:0]         stage_idx;
    logic [IW-1:0]         idx_next;
    logic [NUM_STAGES-1:0] mask_q;
    logic [NUM_STAGES-1:0] mask_next;
    logic [TW-1:0]         timer;

    logic [NUM_STAGES-1:0] search_mask;
    logic [IXW-1:0]        search_from;
    logic                  sel_found;
    logic [IW-1:0]         sel_idx;
    logic                  cur_done;
    logic                  do_select;

    logic                  uart_init_d;
    logic                  uart_enable_d;
    logic                  vga_enable_d;
    logic                  busy_d;
    logic [NUM_STAGES-1:0] stage_enable_d;

    // Lowest masked stage at or above search_from; the mask is not yet latched in S_IDLE.
    always_comb begin
        search_mask = (state == S_IDLE) ? Stage_mask_I : mask_q;
        search_from = (state == S_STAGE_GAP) ? ({1'b0, stage_idx} + IXW'(1)) : '0;
        sel_found   = 1'b0;
        sel_idx     = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if (!sel_found && search_mask[k] && (IXW'(k) >= search_from)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(k);
            end
        end
    end

    // Only the done pulse of the stage currently running counts.
    always_comb begin
        cur_done = 1'b0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if ((stage_idx == IW'(k)) && Stage_done_I[k]) begin
                cur_done = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            stage_idx <= '0;
            mask_q    <= '0;
        end else begin
            state     <= state_next;
            stage_idx <= idx_next;
            mask_q    <= mask_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        idx_next   = stage_idx;
        mask_next  = mask_q;
        do_select  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start_I) begin
                    mask_next = Stage_mask_I;
                    idx_next  = '0;
                    if (SKIP_UART) begin
                        do_select = 1'b1;
                    end else begin
                        state_next = S_UART_INIT;
                    end
                end
            end
            S_UART_INIT: state_next = S_UART_WAIT;
            S_UART_WAIT: begin
                if ((timer == RX_TIMEOUT) && (UART_addr_I != '0)) begin
                    do_select = 1'b1;
                end
            end
            S_STAGE_RUN: begin
                if (cur_done) begin
                    state_next = S_STAGE_GAP;
                end
            end
            S_STAGE_GAP: do_select = 1'b1;
            S_FINISH: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                idx_next   = '0;
            end
        endcase
        if (do_select) begin
            if (sel_found) begin
                state_next = S_STAGE_RUN;
                idx_next   = sel_idx;
            end else begin
                state_next = S_FINISH;
                idx_next   = '0;
            end
        end
    end

    // Output logic: next values of the registered outputs plus the combinational SRAM mux.
    always_comb begin
        uart_init_d       = 1'b0;
        uart_enable_d     = 1'b0;
        vga_enable_d      = 1'b0;
        busy_d            = 1'b0;
        stage_enable_d    = '0;
        SRAM_address_O    = VGA_addr_I;
        SRAM_write_data_O = '0;
        SRAM_we_n_O       = 1'b1;

        uart_enable_d = (state_next == S_UART_INIT);
        uart_init_d   = ((state == S_IDLE) && (state_next == S_UART_INIT)) ||
                        ((state == S_UART_WAIT) && (state_next != S_UART_WAIT));
        vga_enable_d  = (state_next == S_IDLE) || (state_next == S_FINISH);
        busy_d        = (state_next != S_IDLE);
        if (state_next == S_STAGE_RUN) begin
            stage_enable_d = NUM_STAGES'(1) << idx_next;
        end

        if ((state == S_UART_INIT) || (state == S_UART_WAIT)) begin
            SRAM_address_O    = UART_addr_I;
            SRAM_write_data_O = UART_wdata_I;
            SRAM_we_n_O       = UART_we_n_I;
        end else if (state == S_STAGE_RUN) begin
            for (int k = 0; k < int'(NUM_STAGES); k++) begin
                if (stage_idx == IW'(k)) begin
                    SRAM_address_O    = Stage_addr_I[AW*k +: AW];
                    SRAM_write_data_O = Stage_wdata_I[DW*k +: DW];
                    SRAM_we_n_O       = Stage_we_n_I[k];
                end
            end
        end
    end

    // Registered status and control outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            UART_init_O    <= 1'b0;
            UART_enable_O  <= 1'b0;
            VGA_enable_O   <= 1'b1;
            Busy_O         <= 1'b0;
            Stage_enable_O <= '0;
        end else begin
            UART_init_O    <= uart_init_d;
            UART_enable_O  <= uart_enable_d;
            VGA_enable_O   <= vga_enable_d;
            Busy_O         <= busy_d;
            Stage_enable_O <= stage_enable_d;
        end
    end

    // Receive idle timer: restarts on every UART write or receiver re-init, saturates.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            timer <= '0;
        end else if (UART_init_O || !UART_we_n_I) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + TW'(1);
        end
    end

    assign State_O     = state;
    assign Stage_idx_O = stage_idx;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed bench for sram_stage_sequencer: UART load timing, stage ordering, SRAM muxing,
// ignored inputs, the SKIP_UART shortcut and asynchronous reset.
module tb_sram_stage_sequencer;

    localparam int unsigned NS = 3;

    logic          Clock = 1'b0;
    logic          Resetn = 1'b0;
    logic          Start_I = 1'b0;
    logic [NS-1:0] Stage_mask_I = '0;
    logic [17:0]   UART_addr_I = '0;
    logic [15:0]   UART_wdata_I = '0;
    logic          UART_we_n_I = 1'b1;
    logic          UART_init_O, UART_enable_O;
    logic [NS-1:0] Stage_enable_O;
    logic [NS-1:0] Stage_done_I = '0;
    logic [18*NS-1:0] Stage_addr_I = {18'h02C00, 18'h01B00, 18'h00A00};
    logic [16*NS-1:0] Stage_wdata_I = {16'hC0C0, 16'hB0B0, 16'hA0A0};
    logic [NS-1:0] Stage_we_n_I = 3'b010;
    logic [17:0]   VGA_addr_I = 18'h12345;
    logic          VGA_enable_O;
    logic [17:0]   SRAM_address_O;
    logic [15:0]   SRAM_write_data_O;
    logic          SRAM_we_n_O;
    logic [2:0]    State_O, Stage_idx_O;
    logic          Busy_O;

    // Second instance with the UART load bypassed.
    logic          start_s = 1'b0;
    logic [NS-1:0] mask_s = '0;
    logic [NS-1:0] done_s = '0;
    logic          uart_init_s, uart_en_s, vga_en_s, we_n_s, busy_s;
    logic [NS-1:0] en_s;
    logic [17:0]   addr_s;
    logic [15:0]   wdata_s;
    logic [2:0]    st_s, idx_s;
    logic          uart_en_seen_s = 1'b0;

    int cmp = 0;
    int errs = 0;
    int n;

    sram_stage_sequencer #(.NUM_STAGES(NS), .RX_TIMEOUT(26'd20), .SKIP_UART(1'b0)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start_I(Start_I), .Stage_mask_I(Stage_mask_I),
        .UART_addr_I(UART_addr_I), .UART_wdata_I(UART_wdata_I), .UART_we_n_I(UART_we_n_I),
        .UART_init_O(UART_init_O), .UART_enable_O(UART_enable_O),
        .Stage_enable_O(Stage_enable_O), .Stage_done_I(Stage_done_I),
        .Stage_addr_I(Stage_addr_I), .Stage_wdata_I(Stage_wdata_I), .Stage_we_n_I(Stage_we_n_I),
        .VGA_addr_I(VGA_addr_I), .VGA_enable_O(VGA_enable_O),
        .SRAM_address_O(SRAM_address_O), .SRAM_write_data_O(SRAM_write_data_O),
        .SRAM_we_n_O(SRAM_we_n_O), .State_O(State_O), .Stage_idx_O(Stage_idx_O), .Busy_O(Busy_O)
    );

    sram_stage_sequencer #(.NUM_STAGES(NS), .RX_TIMEOUT(26'd20), .SKIP_UART(1'b1)) dut_skip (
        .Clock(Clock), .Resetn(Resetn), .Start_I(start_s), .Stage_mask_I(mask_s),
        .UART_addr_I(UART_addr_I), .UART_wdata_I(UART_wdata_I), .UART_we_n_I(UART_we_n_I),
        .UART_init_O(uart_init_s), .UART_enable_O(uart_en_s),
        .Stage_enable_O(en_s), .Stage_done_I(done_s),
        .Stage_addr_I(Stage_addr_I), .Stage_wdata_I(Stage_wdata_I), .Stage_we_n_I(Stage_we_n_I),
        .VGA_addr_I(VGA_addr_I), .VGA_enable_O(vga_en_s),
        .SRAM_address_O(addr_s), .SRAM_write_data_O(wdata_s),
        .SRAM_we_n_O(we_n_s), .State_O(st_s), .Stage_idx_O(idx_s), .Busy_O(busy_s)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) if (uart_en_s === 1'b1) uart_en_seen_s <= 1'b1;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Advance until UART_init_O rises, returning the number of edges taken (bounded).
    task automatic wait_init(output int cnt);
        cnt = 0;
        while (UART_init_O !== 1'b1 && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    task automatic test_reset();
        UART_we_n_I = 1'b0;
        #7;
        cmp++; if (State_O !== 3'd0) begin errs++; $display("FAIL rst_state: got %0d expected 0", State_O); end
        cmp++; if (Stage_enable_O !== 3'b000) begin errs++; $display("FAIL rst_enable: got %b expected 000", Stage_enable_O); end
        cmp++; if (UART_init_O !== 1'b0 || UART_enable_O !== 1'b0) begin errs++; $display("FAIL rst_uart: got init=%b en=%b expected 0 0", UART_init_O, UART_enable_O); end
        cmp++; if (VGA_enable_O !== 1'b1 || Busy_O !== 1'b0) begin errs++; $display("FAIL rst_vga_busy: got vga=%b busy=%b expected 1 0", VGA_enable_O, Busy_O); end
        cmp++; if (Stage_idx_O !== 3'd0) begin errs++; $display("FAIL rst_idx: got %0d expected 0", Stage_idx_O); end
        cmp++; if (SRAM_we_n_O !== 1'b1 || SRAM_address_O !== 18'h12345) begin errs++; $display("FAIL idle_mux: got we_n=%b addr=%h expected 1 12345", SRAM_we_n_O, SRAM_address_O); end
        @(negedge Clock);
        Resetn = 1'b1;
        UART_we_n_I = 1'b1;
        step();
    endtask

    task automatic test_uart_load();
        UART_addr_I = 18'h3FFFF;
        Start_I = 1'b1;
        Stage_mask_I = 3'b101;
        step();
        Start_I = 1'b0;
        Stage_mask_I = 3'b000;
        cmp++; if (State_O !== 3'd1) begin errs++; $display("FAIL load_init_state: got %0d expected 1", State_O); end
        cmp++; if (UART_init_O !== 1'b1 || UART_enable_O !== 1'b1) begin errs++; $display("FAIL load_init_pulses: got init=%b en=%b expected 1 1", UART_init_O, UART_enable_O); end
        cmp++; if (VGA_enable_O !== 1'b0 || Busy_O !== 1'b1) begin errs++; $display("FAIL load_vga_busy: got vga=%b busy=%b expected 0 1", VGA_enable_O, Busy_O); end
        cmp++; if (SRAM_address_O !== 18'h3FFFF) begin errs++; $display("FAIL load_mux_init: got %h expected 3ffff", SRAM_address_O); end
        step();
        cmp++; if (State_O !== 3'd2 || UART_enable_O !== 1'b0 || UART_init_O !== 1'b0) begin errs++; $display("FAIL load_wait: got st=%0d en=%b init=%b expected 2 0 0", State_O, UART_enable_O, UART_init_O); end
        for (int a = 0; a < 10; a++) begin
            UART_addr_I = 18'(a);
            UART_wdata_I = 16'(a * 3 + 1);
            UART_we_n_I = 1'b0;
            #1;
            cmp++; if (SRAM_address_O !== 18'(a) || SRAM_write_data_O !== 16'(a * 3 + 1) || SRAM_we_n_O !== 1'b0) begin
                errs++; $display("FAIL load_mux_write%0d: got %h/%h/%b expected %h/%h/0", a, SRAM_address_O, SRAM_write_data_O, SRAM_we_n_O, 18'(a), 16'(a * 3 + 1));
            end
            step();
        end
        UART_we_n_I = 1'b1;
        wait_init(n);
        cmp++; if (n !== 21) begin errs++; $display("FAIL load_timeout_latency: got %0d expected 21", n); end
        cmp++; if (State_O !== 3'd3 || Stage_enable_O !== 3'b001 || Stage_idx_O !== 3'd0) begin errs++; $display("FAIL load_first_stage: got st=%0d en=%b idx=%0d expected 3 001 0", State_O, Stage_enable_O, Stage_idx_O); end
    endtask

    task automatic test_stage_sequence();
        step();
        cmp++; if (UART_init_O !== 1'b0 || State_O !== 3'd3) begin errs++; $display("FAIL seq_run0: got init=%b st=%0d expected 0 3", UART_init_O, State_O); end
        cmp++; if (SRAM_address_O !== 18'h00A00 || SRAM_write_data_O !== 16'hA0A0 || SRAM_we_n_O !== 1'b0) begin errs++; $display("FAIL seq_mux0: got %h/%h/%b expected 00a00/a0a0/0", SRAM_address_O, SRAM_write_data_O, SRAM_we_n_O); end
        Stage_done_I = 3'b010;
        Start_I = 1'b1;
        Stage_mask_I = 3'b010;
        step();
        Stage_done_I = 3'b000;
        Start_I = 1'b0;
        cmp++; if (State_O !== 3'd3 || Stage_enable_O !== 3'b001 || SRAM_address_O !== 18'h00A00) begin errs++; $display("FAIL seq_foreign_done: got st=%0d en=%b addr=%h expected 3 001 00a00", State_O, Stage_enable_O, SRAM_address_O); end
        Stage_done_I = 3'b001;
        step();
        Stage_done_I = 3'b000;
        cmp++; if (State_O !== 3'd4 || Stage_enable_O !== 3'b000) begin errs++; $display("FAIL seq_gap: got st=%0d en=%b expected 4 000", State_O, Stage_enable_O); end
        cmp++; if (SRAM_we_n_O !== 1'b1 || SRAM_address_O !== 18'h12345 || SRAM_write_data_O !== 16'h0) begin errs++; $display("FAIL seq_gap_mux: got we_n=%b addr=%h data=%h expected 1 12345 0", SRAM_we_n_O, SRAM_address_O, SRAM_write_data_O); end
        step();
        cmp++; if (State_O !== 3'd3 || Stage_enable_O !== 3'b100 || Stage_idx_O !== 3'd2) begin errs++; $display("FAIL seq_run2: got st=%0d en=%b idx=%0d expected 3 100 2", State_O, Stage_enable_O, Stage_idx_O); end
        cmp++; if (SRAM_address_O !== 18'h02C00 || SRAM_write_data_O !== 16'hC0C0 || SRAM_we_n_O !== 1'b0) begin errs++; $display("FAIL seq_mux2: got %h/%h/%b expected 02c00/c0c0/0", SRAM_address_O, SRAM_write_data_O, SRAM_we_n_O); end
        Stage_done_I = 3'b100;
        step();
        Stage_done_I = 3'b000;
        cmp++; if (State_O !== 3'd4 || Stage_enable_O !== 3'b000) begin errs++; $display("FAIL seq_gap2: got st=%0d en=%b expected 4 000", State_O, Stage_enable_O); end
        step();
        cmp++; if (State_O !== 3'd5 || VGA_enable_O !== 1'b1 || Stage_idx_O !== 3'd0 || Busy_O !== 1'b1) begin errs++; $display("FAIL seq_finish: got st=%0d vga=%b idx=%0d busy=%b expected 5 1 0 1", State_O, VGA_enable_O, Stage_idx_O, Busy_O); end
        step();
        cmp++; if (State_O !== 3'd0 || Busy_O !== 1'b0 || VGA_enable_O !== 1'b1) begin errs++; $display("FAIL seq_idle: got st=%0d busy=%b vga=%b expected 0 0 1", State_O, Busy_O, VGA_enable_O); end
    endtask

    task automatic test_timeout_addr_zero();
        Start_I = 1'b1;
        Stage_mask_I = 3'b010;
        step();
        Start_I = 1'b0;
        step();
        UART_addr_I = 18'h0;
        repeat (40) step();
        cmp++; if (State_O !== 3'd2 || UART_init_O !== 1'b0) begin errs++; $display("FAIL tmo_addr0_hold: got st=%0d init=%b expected 2 0", State_O, UART_init_O); end
        UART_addr_I = 18'h5;
        UART_we_n_I = 1'b0;
        step();
        UART_we_n_I = 1'b1;
        wait_init(n);
        cmp++; if (n !== 21) begin errs++; $display("FAIL tmo_latency: got %0d expected 21", n); end
        cmp++; if (Stage_enable_O !== 3'b010 || Stage_idx_O !== 3'd1) begin errs++; $display("FAIL tmo_stage1: got en=%b idx=%0d expected 010 1", Stage_enable_O, Stage_idx_O); end
        Stage_done_I = 3'b010;
        step();
        Stage_done_I = 3'b000;
        step();
        cmp++; if (State_O !== 3'd5 || Stage_enable_O !== 3'b000) begin errs++; $display("FAIL tmo_finish: got st=%0d en=%b expected 5 000", State_O, Stage_enable_O); end
        step();
    endtask

    task automatic test_mask_zero();
        Start_I = 1'b1;
        Stage_mask_I = 3'b000;
        step();
        Start_I = 1'b0;
        step();
        UART_addr_I = 18'h3;
        UART_we_n_I = 1'b0;
        step();
        UART_we_n_I = 1'b1;
        wait_init(n);
        cmp++; if (n !== 21 || State_O !== 3'd5 || Stage_enable_O !== 3'b000 || VGA_enable_O !== 1'b1) begin
            errs++; $display("FAIL mask0_finish: got n=%0d st=%0d en=%b vga=%b expected 21 5 000 1", n, State_O, Stage_enable_O, VGA_enable_O);
        end
        step();
        cmp++; if (State_O !== 3'd0) begin errs++; $display("FAIL mask0_idle: got %0d expected 0", State_O); end
    endtask

    task automatic test_skip_uart();
        start_s = 1'b1;
        mask_s = 3'b000;
        step();
        start_s = 1'b0;
        cmp++; if (st_s !== 3'd5 || vga_en_s !== 1'b1 || busy_s !== 1'b1) begin errs++; $display("FAIL skip_finish: got st=%0d vga=%b busy=%b expected 5 1 1", st_s, vga_en_s, busy_s); end
        step();
        cmp++; if (st_s !== 3'd0) begin errs++; $display("FAIL skip_idle: got %0d expected 0", st_s); end
        start_s = 1'b1;
        mask_s = 3'b110;
        step();
        start_s = 1'b0;
        cmp++; if (st_s !== 3'd3 || en_s !== 3'b010 || addr_s !== 18'h01B00) begin errs++; $display("FAIL skip_run1: got st=%0d en=%b addr=%h expected 3 010 01b00", st_s, en_s, addr_s); end
        done_s = 3'b010;
        step();
        done_s = 3'b000;
        step();
        cmp++; if (st_s !== 3'd3 || en_s !== 3'b100 || idx_s !== 3'd2) begin errs++; $display("FAIL skip_run2: got st=%0d en=%b idx=%0d expected 3 100 2", st_s, en_s, idx_s); end
        done_s = 3'b100;
        step();
        done_s = 3'b000;
        repeat (2) step();
        cmp++; if (st_s !== 3'd0 || uart_en_seen_s !== 1'b0) begin errs++; $display("FAIL skip_no_uart: got st=%0d uart_en_seen=%b expected 0 0", st_s, uart_en_seen_s); end
    endtask

    task automatic test_reset_mid_stage();
        Start_I = 1'b1;
        Stage_mask_I = 3'b001;
        step();
        Start_I = 1'b0;
        step();
        UART_addr_I = 18'h7;
        UART_we_n_I = 1'b0;
        step();
        UART_we_n_I = 1'b1;
        wait_init(n);
        cmp++; if (State_O !== 3'd3 || Stage_enable_O !== 3'b001) begin errs++; $display("FAIL rmid_running: got st=%0d en=%b expected 3 001", State_O, Stage_enable_O); end
        #2;
        Resetn = 1'b0;
        #1;
        cmp++; if (State_O !== 3'd0 || Stage_enable_O !== 3'b000 || VGA_enable_O !== 1'b1) begin errs++; $display("FAIL rmid_async: got st=%0d en=%b vga=%b expected 0 000 1", State_O, Stage_enable_O, VGA_enable_O); end
        cmp++; if (Busy_O !== 1'b0 || UART_init_O !== 1'b0 || Stage_idx_O !== 3'd0) begin errs++; $display("FAIL rmid_async_misc: got busy=%b init=%b idx=%0d expected 0 0 0", Busy_O, UART_init_O, Stage_idx_O); end
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (3) step();
        cmp++; if (State_O !== 3'd0 || Stage_enable_O !== 3'b000) begin errs++; $display("FAIL rmid_no_resume: got st=%0d en=%b expected 0 000", State_O, Stage_enable_O); end
    endtask

    initial begin
        test_reset();
        test_uart_load();
        test_stage_sequence();
        test_timeout_addr_zero();
        test_mask_zero();
        test_skip_uart();
        test_reset_mid_stage();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded 100000 expected earlier finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_stage_sequencer.md
SRAM_STAGE_SEQUENCER -- requirements
Module: sram_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of processing stages run after an image load (range 1..8).
REQ-002 Parameter RX_TIMEOUT, default 26'd49999999, idle cycles that end a UART transfer.
REQ-003 Parameter SKIP_UART, default 0; when 1, Start_I bypasses the UART load (simulation shortcut).
REQ-004 Clock  in  1  50 MHz system clock; every register updates on its rising edge.
REQ-005 Resetn  in  1  asynchronous, active-low reset.
REQ-006 Start_I  in  1  single-cycle load request (UART start bit or PB0).
REQ-007 Stage_mask_I  in  NUM_STAGES  bit k=1 runs stage k; sampled when Start_I is accepted.
REQ-008 UART_addr_I / UART_wdata_I / UART_we_n_I  in  18/16/1  UART SRAM port.
REQ-009 UART_init_O / UART_enable_O  out  1/1  UART receiver initialize/enable pulses.
REQ-010 Stage_enable_O / Stage_done_I  out/in  NUM_STAGES each  per-stage run level / done pulse.
REQ-011 Stage_addr_I / Stage_wdata_I / Stage_we_n_I  in  18*NUM_STAGES / 16*NUM_STAGES / NUM_STAGES  packed stage SRAM ports; stage k occupies slice k.
REQ-012 VGA_addr_I in 18 and VGA_enable_O out 1: VGA read address and VGA enable.
REQ-013 SRAM_address_O / SRAM_write_data_O / SRAM_we_n_O  out  18/16/1  muxed SRAM controller port.
REQ-014 State_O  out  3; Stage_idx_O  out  3; Busy_O  out  1  status for LEDs.

Function
REQ-015 States SHALL be S_IDLE=0, S_UART_INIT=1, S_UART_WAIT=2, S_STAGE_RUN=3, S_STAGE_GAP=4, S_FINISH=5; State_O SHALL equal the encoding.
REQ-016 S_IDLE: VGA_enable_O=1; Start_I=1 -> UART_init_O=1 pulse, VGA_enable_O=0, latch mask, go S_UART_INIT (SKIP_UART=1: go to first-stage selection instead).
REQ-017 S_UART_INIT: UART_enable_O=1 for exactly one cycle, then S_UART_WAIT.
REQ-018 26-bit timer SHALL clear when UART_init_O=1 or UART_we_n_I=0, else increment by 1, saturating at all-ones.
REQ-019 S_UART_WAIT: timer==RX_TIMEOUT and UART_addr_I!=0 -> UART_init_O pulse, then first-stage selection; UART_addr_I==0 -> remain waiting.
REQ-020 First/next-stage selection: lowest masked index k above the current one; if none -> S_FINISH.
REQ-021 S_STAGE_RUN: Stage_enable_O has only bit k high (registered); Stage_done_I[k]=1 -> clear bit k next edge, go S_STAGE_GAP.
REQ-022 S_STAGE_GAP SHALL last one cycle with all Stage_enable_O=0, then next-stage selection.
REQ-023 Stage_done_I bits other than current k SHALL be ignored.
REQ-024 S_FINISH: VGA_enable_O=1, Stage_idx_O=0, go S_IDLE next cycle.
REQ-025 Start_I outside S_IDLE SHALL be ignored; Busy_O=1 whenever State_O!=S_IDLE.
REQ-026 SRAM mux (combinational): UART states -> UART port; S_STAGE_RUN -> stage-k slice; otherwise address=VGA_addr_I, write_data=0, we_n=1.
REQ-027 SRAM_we_n_O SHALL never be 0 in S_IDLE, S_STAGE_GAP or S_FINISH.
REQ-028 Stage_mask_I==0 SHALL proceed from load completion directly to S_FINISH.

Reset
REQ-029 Resetn=0 SHALL immediately force S_IDLE, timer=0, Stage_idx_O=0, Stage_enable_O=0, UART_init_O=0, UART_enable_O=0, VGA_enable_O=1, Busy_O=0.
REQ-030 Reset mid-stage SHALL drop Stage_enable_O within the same reset assertion; no resume after release.

Verification
REQ-031 Start_I pulse, UART writes to addr 0..9, then idle -> UART_init_O pulse exactly RX_TIMEOUT+1 cycles after the last UART_we_n_I=0, Stage_enable_O=3'b001.
REQ-032 Mask 3'b101, stage0 done, stage2 done -> enable order 001, 000 (one gap cycle), 100, then S_FINISH, VGA_enable_O=1.
REQ-033 Stage_done_I[1] during stage 0 run -> no state change; SRAM_address_O follows stage-0 slice.
REQ-034 Timer expiry with UART_addr_I=0 -> stays in S_UART_WAIT; Start_I during run -> ignored.
REQ-035 SKIP_UART=1, mask 0 -> Start_I yields S_FINISH then S_IDLE, UART_enable_O never asserted.
REQ-036 Resetn low in S_STAGE_RUN -> State_O=0, Stage_enable_O=0, VGA_enable_O=1 same cycle.
